// File: rtl/wrr_pkg.sv
// Shared types for the weighted round-robin client: FSM states, widths, weight vector, output word.
package wrr_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned W    = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned ID_W = $clog2(N);

  typedef logic [N-1:0][W-1:0] weights_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    IDLE = 2'd1,
    ARB  = 2'd2,
    GNT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
  } out_word_t;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [N-1:0] v);
    lowest_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic weights_t weights_reset();
    weights_reset = '0;
    for (int i = 0; i < int'(N); i++) weights_reset[i] = W'(1);
  endfunction

endpackage

// File: rtl/wrr_client_if.sv
// Request/grant/stream bundle between wrr_client and its environment.
interface wrr_client_if;
  import wrr_pkg::*;

  logic [N-1:0]          in_valid;
  logic [N-1:0][DW-1:0]  in_data;
  logic [N-1:0]          in_ready;
  logic [N-1:0]          req;
  logic                  en;
  logic                  load;
  weights_t              weights;
  logic [N-1:0]          gnt;
  weights_t              cfg_weights;
  logic                  cfg_update;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_ready;
  logic                  err;

  modport slave (
    input  in_valid, in_data, gnt, cfg_weights, cfg_update, out_ready,
    output in_ready, req, en, load, weights, out_valid, out_data, out_id, err
  );

  modport master (
    output in_valid, in_data, gnt, cfg_weights, cfg_update, out_ready,
    input  in_ready, req, en, load, weights, out_valid, out_data, out_id, err
  );

endinterface

// File: rtl/wrr_client_fifo.sv
// Single-requester synchronous FIFO; push is dropped when full, pop is dropped when empty.
module wrr_client_fifo #(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head_c,
  output logic          full_c,
  output logic          empty_c
);

  logic [DW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wrr_client.sv
// Requester side of the WRR arbiter: per-requester FIFOs, request/grant sequencing, tagged output
// stream and weight reload. Optional grant checking via WRR_CLIENT_ERR_CHECK_EN.
module wrr_client
  import wrr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FRAME = 16
) (
  input logic          clk,
  input logic          rst,
  wrr_client_if.slave  bus
);

  localparam int unsigned FC_W = $clog2(FRAME + 1);

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    nonempty;
  logic [N-1:0]    full;
  logic [N-1:0]    pop;
  logic [DW-1:0]   head [N];

  weights_t        weights_q;
  logic            reload_pend;
  logic [FC_W-1:0] frame_cnt;
  logic [N-1:0]    req_q;
  logic            en_q;
  logic            load_q;
  out_word_t       out_q;
  logic            out_valid_q;

  logic            out_free_c;
  logic [ID_W-1:0] gnt_idx_c;
  logic            gnt_err_c;
  logic            pop_c;

  for (genvar i = 0; i < int'(N); i++) begin : g_fifo
    logic empty_c;
    wrr_client_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (bus.in_valid[i]),
      .wdata   (bus.in_data[i]),
      .pop     (pop[i]),
      .head_c  (head[i]),
      .full_c  (full[i]),
      .empty_c (empty_c)
    );
    assign nonempty[i] = ~empty_c;
  end

  // Grant decode: a usable grant names a non-empty FIFO and passes the optional check.
  assign out_free_c = ~out_valid_q | bus.out_ready;
  assign gnt_idx_c  = lowest_idx(bus.gnt);
  assign pop_c      = (state == GNT) && (bus.gnt != '0) && !gnt_err_c && nonempty[gnt_idx_c];

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N); i++) begin
      pop[i] = pop_c && (gnt_idx_c == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // The reset-entry LOAD lingers one cycle so the load pulse is seen after reset release.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: state_nxt = load_q ? IDLE : LOAD;
      IDLE: begin
        if (reload_pend || (frame_cnt == FC_W'(FRAME)))  state_nxt = LOAD;
        else if ((nonempty != '0) && out_free_c)          state_nxt = ARB;
      end
      ARB:  state_nxt = GNT;
      GNT:  state_nxt = IDLE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      req_q       <= '0;
      frame_cnt   <= '0;
      reload_pend <= 1'b0;
      weights_q   <= weights_reset();
    end else begin
      load_q <= (state_nxt == LOAD);
      en_q   <= (state_nxt == ARB);
      req_q  <= (state_nxt == ARB) ? nonempty : '0;
      if (bus.cfg_update) weights_q <= bus.cfg_weights;
      if (state == LOAD) begin
        frame_cnt   <= '0;
        reload_pend <= bus.cfg_update;
      end else begin
        if (bus.cfg_update) reload_pend <= 1'b1;
        if (pop_c && (frame_cnt != FC_W'(FRAME))) frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (pop_c) begin
      out_q       <= '{id: gnt_idx_c, data: head[gnt_idx_c]};
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef WRR_CLIENT_ERR_CHECK_EN
  logic [N-1:0] req_snap;
  logic         err_q;

  // req_q is already cleared in GNT, so the request mask is kept separately for checking.
  assign gnt_err_c = !$onehot(bus.gnt) || ((bus.gnt & ~req_snap) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_snap <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_nxt == ARB)           req_snap <= nonempty;
      if ((state == GNT) && gnt_err_c) err_q    <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign gnt_err_c = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.in_ready  = ~full;
  assign bus.req       = req_q;
  assign bus.en        = en_q;
  assign bus.load      = load_q;
  assign bus.weights   = weights_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_id    = out_q.id;

endmodule

// File: tb/tb_wrr_client.sv
// Self-checking bench for wrr_client: directed scenarios plus randomized traffic against a queue model.
module tb_wrr_client;
  import wrr_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wrr_client_if bus();

  wrr_client #(.DEPTH(DEPTH), .FRAME(FRAME)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per requester plus the words expected on the output stream.
  logic [DW-1:0] mq [N][$];
  out_word_t     exp_q[$];
  weights_t      m_weights;
  logic          m_err;
  logic          m_pend;
  int            grants_since_load;
  int            ens_pend;
  int            n_loads;
  logic          gnt_live;
  logic          gnt_clear;
  logic [N-1:0]  m_req;

  // Stimulus for the next clock edge.
  logic [N-1:0]         s_valid;
  logic [N-1:0][DW-1:0] s_data;
  logic                 s_ready;
  logic                 s_cfg;
  weights_t             s_cfg_w;
  logic                 force_gnt;
  logic [N-1:0]         forced_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) mq[i].delete();
    exp_q.delete();
    for (int i = 0; i < int'(N); i++) m_weights[i] = W'(1);
    m_err = 1'b0; m_pend = 1'b0; grants_since_load = 0; ens_pend = 0;
    gnt_live = 1'b0; gnt_clear = 1'b0; m_req = '0;
  endtask

  task automatic stim_idle();
    s_valid = '0; s_data = '0; s_ready = 1'b0; s_cfg = 1'b0; s_cfg_w = '0;
    force_gnt = 1'b0; forced_gnt = '0;
    bus.in_valid = '0; bus.in_data = '0; bus.gnt = '0; bus.cfg_weights = '0;
    bus.cfg_update = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    weights_t ones;
    for (int i = 0; i < int'(N); i++) ones[i] = W'(1);
    check({tag, "_req"},       32'(bus.req), 0);
    check({tag, "_en"},        32'(bus.en), 0);
    check({tag, "_load"},      32'(bus.load), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  32'(bus.out_data), 0);
    check({tag, "_out_id"},    32'(bus.out_id), 0);
    check({tag, "_err"},       32'(bus.err), 0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'hFF);
    check({tag, "_weights"},   32'(bus.weights), 32'(ones));
  endtask

  // One cycle: sample at the falling edge, check against the model, advance the model, drive.
  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] exp_ready;
    logic [N-1:0] g;
    int           k;
    int           cand[$];
    out_word_t    w;
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) exp_ready[i] = (mq[i].size() != int'(DEPTH));
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("weights", 32'(bus.weights), 32'(m_weights));
    check("err", 32'(bus.err), 32'(m_err));
    check("load_en_excl", 32'(bus.load & bus.en), 0);
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (bus.out_valid && exp_q.size() != 0)
      check("out_word", 32'({bus.out_id, bus.out_data}), 32'(exp_q[0]));

    if (bus.load) begin
      n_loads++;
      grants_since_load = 0;
      if (!s_cfg) begin m_pend = 1'b0; ens_pend = 0; end
    end
    if (bus.en) begin
      check("frame_budget", 32'(grants_since_load < int'(FRAME)), 1);
      if (m_pend) ens_pend++;
      check("reload_prompt", 32'(ens_pend <= 1), 1);
    end

    for (int i = 0; i < int'(N); i++) acc[i] = s_valid[i] && (mq[i].size() < int'(DEPTH));
    if (bus.out_valid && s_ready && exp_q.size() != 0) void'(exp_q.pop_front());

    if (gnt_live) begin
      g = bus.gnt;
      k = -1;
      for (int i = int'(N) - 1; i >= 0; i--) if (g[i]) k = i;
`ifdef WRR_CLIENT_ERR_CHECK_EN
      if (!$onehot(g) || ((g & ~m_req) != '0)) begin
        m_err = 1'b1;
        k = -1;
      end
`endif
      if (k >= 0 && mq[k].size() > 0) begin
        w.id   = ID_W'(k);
        w.data = mq[k].pop_front();
        exp_q.push_back(w);
        grants_since_load++;
      end
      gnt_live  = 1'b0;
      gnt_clear = 1'b1;
    end else if (gnt_clear) begin
      bus.gnt   = '0;
      gnt_clear = 1'b0;
    end

    // Play the arbiter: grant one requested index, held through the GNT cycle.
    if (bus.en) begin
      m_req = bus.req;
      if (force_gnt) begin
        g = forced_gnt;
        force_gnt = 1'b0;
      end else begin
        for (int i = 0; i < int'(N); i++) if (bus.req[i]) cand.push_back(i);
        g = '0;
        if (cand.size() > 0) g[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
      end
      bus.gnt  = g;
      gnt_live = 1'b1;
    end

    for (int i = 0; i < int'(N); i++) if (acc[i]) mq[i].push_back(s_data[i]);
    if (s_cfg) begin m_weights = s_cfg_w; m_pend = 1'b1; end

    bus.in_valid    = s_valid;
    bus.in_data     = s_data;
    bus.out_ready   = s_ready;
    bus.cfg_update  = s_cfg;
    bus.cfg_weights = s_cfg_w;
  endtask

  function automatic logic all_empty();
    all_empty = (exp_q.size() == 0);
    for (int i = 0; i < int'(N); i++) if (mq[i].size() != 0) all_empty = 1'b0;
  endfunction

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        s_valid[i] = ($urandom_range(0, 3) == 0);
        s_data[i]  = DW'($urandom);
      end
      s_ready = ($urandom_range(0, 3) != 0);
      s_cfg   = ($urandom_range(0, 19) == 0);
      s_cfg_w = weights_t'($urandom);
      step();
    end
    s_valid = '0; s_cfg = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    s_valid = '0; s_cfg = 1'b0; s_ready = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      step();
      done = all_empty();
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    int   loads0;
    logic seen;
    logic ready0_back;

    rst = 1'b1;
    n_loads = 0;
    stim_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // First cycle after release is the load pulse; push 0xA5 on requester 3 in that cycle.
    s_valid = 8'h08;
    s_data[3] = 8'hA5;
    step();
    check("cycle1_load", 32'(bus.load), 1);
    check("cycle1_in_ready", 32'(bus.in_ready), 32'hFF);
    s_valid = '0;
    step();
    check("t1_en", 32'(bus.en), 0);
    step();
    check("t2_en", 32'(bus.en), 1);
    check("t2_req", 32'(bus.req), 32'h08);
    step();
    check("t3_out_valid", 32'(bus.out_valid), 0);
    step();
    check("t4_out_valid", 32'(bus.out_valid), 1);
    check("t4_out_data", 32'(bus.out_data), 32'hA5);
    check("t4_out_id", 32'(bus.out_id), 3);

    // Output held: fill requester 0 past its depth; nothing may be arbitrated meanwhile.
    for (int p = 0; p < 5; p++) begin
      s_valid = (p == 0) ? 8'h21 : 8'h01;
      s_data[0] = DW'(8'h10 + p);
      s_data[5] = 8'h5C;
      step();
      check("hold_no_en", 32'(bus.en), 0);
      check("hold_data", 32'(bus.out_data), 32'hA5);
    end
    s_valid = '0;
    check("fifo0_full", 32'(bus.in_ready[0]), 0);
    repeat (3) begin
      step();
      check("hold_no_en", 32'(bus.en), 0);
      check("fifo0_still_full", 32'(bus.in_ready[0]), 0);
    end

    // Release the output: six grants with FRAME=2 give three reload pulses.
    loads0 = n_loads;
    ready0_back = 1'b0;
    s_ready = 1'b1;
    for (int c = 0; c < 200 && !all_empty(); c++) begin
      step();
      if (bus.in_ready[0]) ready0_back = 1'b1;
    end
    repeat (4) step();
    check("fifo0_ready_after_pop", 32'(ready0_back), 1);
    check("frame_reloads", 32'(n_loads - loads0), 3);

    // Weight update reloads promptly.
    s_cfg = 1'b1;
    s_cfg_w = weights_t'(24'h5A3C71);
    loads0 = n_loads;
    step();
    s_cfg = 1'b0;
    repeat (4) step();
    check("cfg_reload", 32'(n_loads - loads0), 1);

    // Multi-bit grant on requesters 0 and 1.
    s_valid = 8'h03;
    s_data[0] = 8'h11;
    s_data[1] = 8'h22;
    force_gnt = 1'b1;
    forced_gnt = 8'h03;
    step();
    s_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = bus.en;
    end
    check("bad_gnt_en_seen", 32'(seen), 1);
    step();
    step();
`ifdef WRR_CLIENT_ERR_CHECK_EN
    check("bad_gnt_err", 32'(bus.err), 1);
    check("bad_gnt_no_pop", 32'(bus.out_valid), 0);
`else
    check("bad_gnt_err", 32'(bus.err), 0);
    check("bad_gnt_pop_valid", 32'(bus.out_valid), 1);
    check("bad_gnt_pop_id", 32'(bus.out_id), 0);
    check("bad_gnt_pop_data", 32'(bus.out_data), 32'h11);
`endif
    drain("drain_bad_gnt");

    random_phase(600);

    // Reset in the middle of traffic.
    random_phase(37);
    rst = 1'b1;
    #1;
    model_reset();
    stim_idle();
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    step();
    check("midreset_load", 32'(bus.load), 1);

    random_phase(600);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
